note_scroller: RTL and testbench
================================

Name: note_scroller

Overview:
- Upstream timing and note-feed stage for the hit scanner.
- Generates the free-running beat `counter` and the selected `lim`.
- Scrolls a 40-slot note column (`padded_notes`) one slot per beat, filling it from a combinational song-pattern ROM.
- Bit 37 of `padded_notes` is the strike-zone slot the scanner reads; a note enters at bit 0 and reaches bit 37 after 37 steps.

Parameters:
- SONG_LEN, 256, number of 1-bit pattern entries in the song ROM.
- ADDR_W, 8, width of `song_addr`; must satisfy 2^ADDR_W >= SONG_LEN.
- LIM_SLOW, 23'd6048000, beat period in clocks for speed 00.
- LIM_MED, 23'd4536000, beat period for speed 01.
- LIM_FAST, 23'd3024000, beat period for speed 10 and 11.
- All LIM_* values must lie in [21, 2^23-1]. This keeps the scanner's lim-10 and 10 compare points distinct.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  synchronous active-low reset; sampled on the rising edge of clk.
- start  in  1  one-cycle start request.
- pause  in  1  level; freezes all play progress while high.
- speed  in  2  difficulty select; sampled only on an accepted start.
- song_bit  in  1  ROM data for `song_addr`, valid in the same cycle.
- song_addr  out  ADDR_W  ROM read address.
- counter  out  23  beat-phase counter, 0..lim-1.
- lim  out  23  latched beat period.
- padded_notes  out  40  note column; [37] is the strike zone.
- step  out  1  one-cycle pulse on each scroll.
- playing  out  1  high in PLAY or DRAIN.
- done  out  1  high in DONE.

Behaviour:
- Reset (n_rst low at a clk edge, any state):
  - state=IDLE.
  - counter=0, lim=LIM_SLOW, padded_notes=0, song_addr=0.
  - step=0, playing=0, done=0, drain count=0.
  - Reset mid-song abandons the song; there is no partial state.
- All outputs are registered.
- IDLE:
  - Outputs hold at reset values.
  - start=1 latches lim from speed, clears song_addr, counter and padded_notes, then goes to PLAY.
- PLAY:
  - Each cycle with pause=0: if counter != lim-1, counter <= counter+1.
  - If counter == lim-1 (wrap):
    - counter <= 0.
    - padded_notes <= {padded_notes[38:0], song_bit}.
    - step <= 1 for exactly one cycle, coincident with counter==0.
    - If song_addr == SONG_LEN-1: go to DRAIN, song_addr holds, drain count <= 0.
    - Otherwise song_addr <= song_addr+1.
- DRAIN:
  - Counting and wrap behave as in PLAY, except the inserted bit is 0.
  - Each wrap increments the 6-bit drain count.
  - The wrap at which drain count == 39 (the 40th drain step) goes to DONE. padded_notes is then all-zero.
- DONE:
  - done=1, playing=0, counter=0, padded_notes=0, step=0.
  - start=1 behaves exactly as start in IDLE and returns to PLAY.
- pause=1 in PLAY or DRAIN freezes counter, padded_notes, song_addr and drain count. step stays 0.
  - On release, counting resumes from the frozen counter value. No step is lost or duplicated.
  - pause has no effect in IDLE or DONE.
- start in PLAY or DRAIN is ignored. speed changes mid-song are ignored; lim is constant between accepted starts.
- Simultaneous start and pause in IDLE/DONE: start is accepted; PLAY is entered and the first cycle is frozen by pause.
- The first step of a song occurs lim cycles after the start-accept edge. Counter goes 0,1,…,lim-1, then wraps.
- The scanner's lim-10 / 10 window straddles each wrap. A note reaches bit 37 at step 37 after its insert step.

Test Plan:
- Reset behaviour: hold n_rst=0 for 3 cycles during PLAY, then release. Required: all outputs at reset values; state IDLE; no step until a new start.
- Basic scroll: LIM_FAST=24, speed=10, SONG_LEN=8, ROM=10110001 (addr0 first), start. Required:
  - lim=24.
  - step every 24 cycles, first 24 cycles after start.
  - After 8 steps padded_notes[7:0]=8'b10110001.
  - song_addr sequence 0..7.
- Strike-zone arrival: same setup. Required: padded_notes[37]=1 first after step 38, matching ROM addr0=1.
- Pause: pause high for 50 cycles at counter=5. Required: counter stays 5, no step, song_addr frozen. After release the next step occurs 19 cycles later.
- Drain and done: SONG_LEN=8. Required:
  - After step 8 the state is DRAIN.
  - 40 further steps, then done=1, playing=0, padded_notes=0.
  - Subsequent start with speed=00 gives lim=LIM_SLOW and playing=1.
- Start and speed ignored mid-song: pulse start and change speed to 00 during PLAY. Required: lim, counter, song_addr and padded_notes unaffected.

Source files
------------

// File: rtl/note_scroller.sv
// note_scroller
//   Upstream timing and note-feed stage for the hit scanner. Produces the
//   free-running beat-phase counter and the selected beat period, and scrolls
//   a 40-slot note column one slot per beat. The column is filled from an
//   external combinational song ROM. Bit 37 of the column is the strike zone.
//
// Ports
//   clk           system clock
//   n_rst         synchronous active-low reset
//   start         one-cycle start request (accepted in IDLE/DONE only)
//   pause         level; freezes play progress while high
//   speed         difficulty select, sampled on an accepted start
//   song_bit      ROM data for song_addr, valid in the same cycle
//   song_addr     ROM read address
//   counter       beat-phase counter, 0..lim-1
//   lim           latched beat period
//   padded_notes  note column, [37] is the strike zone
//   step          one-cycle pulse on each scroll (coincident with counter==0)
//   playing       high in PLAY or DRAIN
//   done          high in DONE
module note_scroller #(
  parameter int          SONG_LEN = 256,
  parameter int          ADDR_W   = 8,
  parameter logic [22:0] LIM_SLOW = 23'd6048000,
  parameter logic [22:0] LIM_MED  = 23'd4536000,
  parameter logic [22:0] LIM_FAST = 23'd3024000
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              pause,
  input  logic [1:0]        speed,
  input  logic              song_bit,
  output logic [ADDR_W-1:0] song_addr,
  output logic [22:0]       counter,
  output logic [22:0]       lim,
  output logic [39:0]       padded_notes,
  output logic              step,
  output logic              playing,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, PLAY, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

  state_t      state;
  logic [5:0]  drain_cnt;
  logic [22:0] lim_sel;
  logic        wrap;

  always_comb begin
    lim_sel = LIM_FAST;
    case (speed)
      2'b00:   lim_sel = LIM_SLOW;
      2'b01:   lim_sel = LIM_MED;
      default: lim_sel = LIM_FAST;
    endcase
  end

  assign wrap = (counter == lim - 23'd1);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state        <= IDLE;
      counter      <= '0;
      lim          <= LIM_SLOW;
      padded_notes <= '0;
      song_addr    <= '0;
      drain_cnt    <= '0;
      step         <= 1'b0;
      playing      <= 1'b0;
      done         <= 1'b0;
    end else begin
      step <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            lim          <= lim_sel;
            song_addr    <= '0;
            counter      <= '0;
            padded_notes <= '0;
            drain_cnt    <= '0;
            playing      <= 1'b1;
            done         <= 1'b0;
            state        <= PLAY;
          end
        end
        PLAY, DRAIN: begin
          // pause freezes everything, including the step pulse
          if (!pause) begin
            if (wrap) begin
              counter      <= '0;
              step         <= 1'b1;
              // once the song is exhausted, zeros flush the column
              padded_notes <= {padded_notes[38:0], (state == PLAY) ? song_bit : 1'b0};
              if (state == PLAY) begin
                if (song_addr == LAST_ADDR) begin
                  state     <= DRAIN;
                  drain_cnt <= '0;
                end else begin
                  song_addr <= song_addr + ADDR_W'(1);
                end
              end else begin
                drain_cnt <= drain_cnt + 6'd1;
                // 40th drain step: every song bit has left the column
                if (drain_cnt == 6'd39) begin
                  state        <= DONE;
                  playing      <= 1'b0;
                  done         <= 1'b1;
                  padded_notes <= '0;
                end
              end
            end else begin
              counter <= counter + 23'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_scroller.sv
module tb_note_scroller;
  localparam int LS = 40, LM = 32, LF = 24, SL = 8, NSTEP = SL + 40;

  logic        clk = 1'b0, n_rst = 1'b0, start = 1'b0, pause = 1'b0;
  logic [1:0]  speed = 2'b00;
  logic        song_bit;
  logic [7:0]  song_addr;
  logic [22:0] counter, lim;
  logic [39:0] padded_notes;
  logic        step, playing, done;

  logic [7:0]  rom_pat = 8'b10110001;   // addr0 is the MSB
  always_comb song_bit = rom_pat[3'd7 - song_addr[2:0]];

  note_scroller #(
    .SONG_LEN(SL), .ADDR_W(8),
    .LIM_SLOW(23'(LS)), .LIM_MED(23'(LM)), .LIM_FAST(23'(LF))
  ) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .pause(pause), .speed(speed),
    .song_bit(song_bit), .song_addr(song_addr), .counter(counter), .lim(lim),
    .padded_notes(padded_notes), .step(step), .playing(playing), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_rst(input string nm);
    chk(nm, {counter, lim, padded_notes, song_addr, step, playing, done},
            {23'd0, 23'(LS), 40'd0, 8'd0, 3'b000});
  endtask

  // scoreboard of expected step events
  typedef struct {
    logic [39:0] pad;
    logic [7:0]  addr;
    logic        last;
  } step_t;
  step_t sbq[$];

  bit tb_active = 1'b0;
  int act_cnt = 0, nsteps = 0, first_hit = 0;

  always @(posedge clk) begin
    logic  p, a;
    step_t e;
    p = pause;
    a = tb_active && n_rst;
    #1;
    if (a && p) chk("pause_no_step", step, 1'b0);
    if (a && !p) act_cnt++;
    if (step) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_step: got step=1 expected no step (counter=%0d)", counter);
      end else begin
        e = sbq.pop_front();
        nsteps++;
        chk("step_interval", act_cnt, LF);
        chk("step_pad", padded_notes, e.pad);
        chk("step_addr", song_addr, e.addr);
        chk("step_done", done, e.last);
        chk("step_playing", playing, !e.last);
        chk("step_cnt0", counter, 0);
        if (first_hit == 0 && padded_notes[37]) first_hit = nsteps;
      end
      act_cnt = 0;
    end
  end

  // lim selection / start-with-pause vectors
  typedef struct {
    logic [1:0]  spd;
    logic        pz;
    logic [22:0] exp_lim;
    logic [22:0] exp_cnt;
  } vec_t;
  vec_t vt[6];

  initial begin
    logic [39:0] m, snap_pad;
    logic        b;
    int          n;

    vt[0] = '{2'b00, 1'b0, 23'(LS), 23'd1};
    vt[1] = '{2'b01, 1'b0, 23'(LM), 23'd1};
    vt[2] = '{2'b10, 1'b0, 23'(LF), 23'd1};
    vt[3] = '{2'b11, 1'b0, 23'(LF), 23'd1};
    vt[4] = '{2'b10, 1'b1, 23'(LF), 23'd0};
    vt[5] = '{2'b01, 1'b1, 23'(LM), 23'd0};

    for (int i = 0; i < 6; i++) begin
      n_rst = 1'b0;
      repeat (2) @(negedge clk);
      chk_rst("vec_reset");
      n_rst = 1'b1;
      speed = vt[i].spd; pause = vt[i].pz; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("vec_lim", lim, vt[i].exp_lim);
      chk("vec_play", {playing, done, counter}, {2'b10, 23'd0});
      @(negedge clk);
      pause = 1'b0;
      chk("vec_cnt", counter, vt[i].exp_cnt);
    end

    // full song run at LIM_FAST
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    m = '0;
    for (int k = 1; k <= NSTEP; k++) begin
      b = (k <= SL) ? rom_pat[SL - k] : 1'b0;
      m = {m[38:0], b};
      sbq.push_back('{m, 8'((k < SL) ? k : SL - 1), k == NSTEP});
    end
    speed = 2'b10; start = 1'b1;
    @(negedge clk);
    start = 1'b0; tb_active = 1'b1; act_cnt = 0;
    chk("song_lim", lim, LF);

    // pause at counter 5 after step 2
    n = 0;
    while (!(song_addr == 8'd2 && counter == 23'd5) && n < 200) begin @(negedge clk); n++; end
    chk("pause_reach", n < 200, 1'b1);
    pause = 1'b1;
    repeat (50) @(negedge clk);
    chk("pause_cnt", counter, 5);
    chk("pause_addr", song_addr, 2);
    pause = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!step && n < 40);
    chk("resume_gap", n, 19);

    // start + speed change mid-song must be ignored
    n = 0;
    while (!(song_addr == 8'd4 && counter == 23'd3) && n < 200) begin @(negedge clk); n++; end
    chk("midstart_reach", n < 200, 1'b1);
    snap_pad = padded_notes;
    start = 1'b1; speed = 2'b00;
    @(negedge clk);
    start = 1'b0;
    chk("mid_lim", lim, LF);
    chk("mid_cnt", counter, 4);
    chk("mid_addr", song_addr, 4);
    chk("mid_pad", padded_notes, snap_pad);
    chk("mid_play", playing, 1'b1);

    // end of song: DRAIN begins, still playing
    n = 0;
    while (nsteps < SL && n < 500) begin @(negedge clk); n++; end
    chk("drain_enter", {playing, done, song_addr}, {2'b10, 8'd7});

    n = 0;
    while (nsteps < NSTEP && n < 2000) begin @(negedge clk); n++; end
    chk("done_reach", nsteps, NSTEP);
    chk("done_out", {done, playing, counter, padded_notes}, {2'b10, 23'd0, 40'd0});
    chk("sb_empty", sbq.size(), 0);
    chk("strike_first", first_hit, 38);
    tb_active = 1'b0;
    pause = 1'b1;
    repeat (5) @(negedge clk);
    chk("done_hold", {done, playing, step, counter}, {3'b100, 23'd0});
    pause = 1'b0;

    // restart from DONE at slow speed
    speed = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart", {lim, playing, done, counter}, {23'(LS), 2'b10, 23'd0});
    repeat (10) @(negedge clk);
    chk("restart_cnt", counter, 10);

    // reset mid-play for 3 cycles
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_rst("midplay_reset");
    n_rst = 1'b1;
    repeat (60) @(negedge clk);
    chk_rst("post_reset_idle");
    chk("post_reset_steps", nsteps, NSTEP);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
